// File: rtl/rsa_encrypt_core.sv
// rsa_encrypt_core: constant-time RSA encryption c = msg^e mod n using right-to-left
// binary exponentiation and bit-serial interleaved shift-add modular multiplication.
module rsa_encrypt_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] msg,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] c
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, FINISH} state_t;

    state_t           state;
    logic [WIDTH-1:0] n_r, e_r, msg_r;
    logic [WIDTH:0]   res, base, acc_p, acc_s, p_next, s_next;
    logic [CW-1:0]    step, bit_idx;
    logic             bad;

    // One interleaved step: acc = 2*acc mod m, then optionally acc = acc + a mod m.
    // Operands stay below m, so every intermediate fits in WIDTH+1 bits and one
    // conditional subtract suffices for each reduction.
    function automatic logic [WIDTH:0] mod_step(input logic [WIDTH:0] acc,
                                                input logic [WIDTH:0] a,
                                                input logic bj,
                                                input logic [WIDTH-1:0] m);
        logic [WIDTH:0] mm, d, t;
        mm = {1'b0, m};
        d  = acc << 1;
        if (d >= mm) d = d - mm;
        t = bj ? d + a : d;
        if (t >= mm) t = t - mm;
        return t;
    endfunction

    // Both multipliers share the step counter and scan the bits of base MSB first.
    always_comb begin
        p_next = mod_step(acc_p, res, base[step], n_r);
        s_next = mod_step(acc_s, base, base[step], n_r);
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            c       <= '0;
            n_r     <= '0;
            e_r     <= '0;
            msg_r   <= '0;
            res     <= '0;
            base    <= '0;
            acc_p   <= '0;
            acc_s   <= '0;
            step    <= '0;
            bit_idx <= '0;
            bad     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_r   <= n;
                        e_r   <= e;
                        msg_r <= msg;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (n_r < WIDTH'(2) || msg_r >= n_r) begin
                        bad   <= 1'b1;
                        state <= FINISH;
                    end else begin
                        bad     <= 1'b0;
                        res     <= (WIDTH+1)'(1);
                        base    <= {1'b0, msg_r};
                        bit_idx <= '0;
                        step    <= LAST;
                        acc_p   <= '0;
                        acc_s   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (step == '0) begin
                        if (e_r[bit_idx]) res <= p_next;
                        base    <= s_next;
                        acc_p   <= '0;
                        acc_s   <= '0;
                        step    <= LAST;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST) state <= FINISH;
                    end else begin
                        acc_p <= p_next;
                        acc_s <= s_next;
                        step  <= step - 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    err   <= bad;
                    c     <= bad ? '0 : res[WIDTH-1:0];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rsa_encrypt_core.md
Name: rsa_encrypt_core

Overview:
- Computes RSA ciphertext c = msg^e mod n by constant-time right-to-left binary exponentiation.
- Modular multiplication uses bit-serial interleaved shift-add.
- Encryption-side counterpart to the team's CRT decryption block; its output feeds that block for round-trip checks.
- Start/busy/done handshake; one exponent bit is processed per WIDTH cycles.

Parameters:
WIDTH, 32, operand width in bits of n, e, msg and c; legal range 4..32.

Ports:
clk    input   1      system clock, rising edge
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only when idle
n      input   WIDTH  modulus; captured on start acceptance
e      input   WIDTH  public exponent; captured on start acceptance
msg    input   WIDTH  plaintext; captured on start acceptance
busy   output  1      high from the cycle after acceptance until done
done   output  1      one-cycle completion pulse
err    output  1      operand error flag; valid with done, held until the next acceptance
c      output  WIDTH  ciphertext; updates only with done, held until the next completion

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE and busy=0, done=0, err=0, c=0. All internal registers clear. Reset mid-operation aborts with no done pulse.
- States: IDLE, CHECK, RUN, FINISH.
- IDLE:
  - start=1 at edge k captures n, e, msg and goes to CHECK. busy=1 from k+1.
  - start while busy is ignored and has no effect on the running operation.
- CHECK (1 cycle):
  - If n<2 or msg>=n: go to FINISH with err=1, c=0.
  - Otherwise set res=1, base=msg, bit index=0, and go to RUN.
- RUN: WIDTH exponent bits, LSB first, WIDTH cycles per bit, total WIDTH*WIDTH cycles.
  - Per bit, two multipliers run in parallel and share the step counter:
    - P = res*base mod n
    - S = base*base mod n
  - Each multiplier: acc=0; for j=WIDTH-1 downto 0, acc=2*acc mod n, then if b[j], acc=acc+a mod n.
  - Each reduction is a single conditional subtract of n.
  - Internal acc width is WIDTH+1 bits, which covers 2*acc<2n and acc+a<2n. No overflow is permitted.
  - At the end of the bit: res<=P if e[bit]=1, else res unchanged; base<=S always.
  - Both products are computed regardless of the exponent bit (constant time, no early exit on leading zeros).
  - After bit WIDTH-1, go to FINISH.
- FINISH (1 cycle): done=1, c<=res (or 0 on err), err registered, busy=0 on the same edge, then return to IDLE.
- Latency:
  - start sampled at edge k gives done high in cycle k+WIDTH*WIDTH+2 (1026 for WIDTH=32).
  - Error path gives done in cycle k+2.
- start=1 in the same cycle as done (FINISH) is ignored. A new start is accepted in IDLE one cycle later, so back-to-back throughput is one operation per WIDTH*WIDTH+3 cycles.
- Boundary cases:
  - e=0 gives c=1 (n>=2).
  - msg=0 gives c=0 for e>0, and c=1 for e=0.
  - msg=1 gives c=1.
  - n=2^WIDTH-1 must not overflow.
- All arithmetic is unsigned. Inputs may change after acceptance without affecting the result.

Test Plan:
- WIDTH=32, n=3233, e=17, msg=65: done exactly 1026 cycles after start, c=2790, err=0. Reapplying with e=2753, msg=2790 gives c=65.
- n=3233, msg=4000 (msg>=n): done at start+2, err=1, c=0, busy low after. Then n=1, msg=0 also gives err=1.
- n=3233, msg=65, e=0 gives c=1. msg=0, e=5 gives c=0. msg=1, e=0xFFFFFFFF gives c=1. All with identical 1026-cycle latency.
- n=0xFFFFFFFB (prime 4294967291), msg=2, e=0xFFFFFFFA gives c=1 (Fermat), confirming there is no wide-operand overflow.
- Start a run, then pulse start repeatedly while busy, and change n/e/msg mid-run: the result is still 2790. rst_n low at cycle 500 gives immediate busy=0, done=0, c=0, no later done. A fresh start after release completes normally.
- Back-to-back: start held high continuously gives a done every 1027 cycles with correct c each time. c is held stable between done pulses.
